// File: rtl/shadow_pkg.sv
// Shared definitions for the Shadow-512 Lbox layer sequencer: FSM state
// encoding, default geometry and a width helper.
package shadow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } seq_state_t;

  localparam int DEF_NBITS    = 128;
  localparam int DEF_NBUNDLES = 4;
  // One Lbox acts on a pair of 32-bit words.
  localparam int LBOX_W       = 64;

  // ceil(log2(value)), never less than 1 so counters always have a bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/lbox_unit.sv
// Combinational Lbox datapath: applies the Shadow Lbox to every 64-bit
// lane of one slice (x = lane[31:0], y = lane[63:32]). The slice width is
// Nbits >> PDLBOX, so one instance serves both serialization settings.
module lbox_unit
  import shadow_pkg::*;
#(
  parameter int PDLBOX = 0,
  parameter int Nbits  = DEF_NBITS
) (
  input  logic [(Nbits >> PDLBOX)-1:0] i_slice,
  output logic [(Nbits >> PDLBOX)-1:0] o_slice
);

  localparam int SW  = Nbits >> PDLBOX;
  localparam int NLB = SW / LBOX_W;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] lbox64(input logic [63:0] v);
    logic [31:0] x, y, a, b, c, d;
    x = v[31:0];
    y = v[63:32];
    a = x ^ rotr(x, 12);
    b = y ^ rotr(y, 12);
    a = a ^ rotr(a, 3);
    b = b ^ rotr(b, 3);
    a = a ^ rotr(x, 17);
    b = b ^ rotr(y, 17);
    c = a ^ rotr(a, 31);
    d = b ^ rotr(b, 31);
    a = a ^ rotr(d, 26);
    b = b ^ rotr(c, 25);
    a = a ^ rotr(c, 15);
    b = b ^ rotr(d, 15);
    return {b, a};
  endfunction

  // Independent Lbox per 64-bit lane, no state.
  for (genvar g = 0; g < NLB; g++) begin : g_lane
    assign o_slice[g*LBOX_W +: LBOX_W] = lbox64(i_slice[g*LBOX_W +: LBOX_W]);
  end

endmodule

// File: rtl/lbox_layer_seq.sv
// Lbox layer sequencer. Captures one bundle, streams its 2^PDLBOX slices
// through a single lbox_unit on consecutive cycles, then presents the
// reassembled result. Counts output bundles and pulses layer_done at the
// end of each layer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds with stable data until that edge.
//
// Build option LBOX_LAYER_SEQ_OVERLAP_EN: in OUT, in_ready follows
// out_ready so a new bundle is taken in the same edge as the result leaves
// and the FSM goes straight back to RUN.
module lbox_layer_seq
  import shadow_pkg::*;
#(
  parameter int PDLBOX   = 0,
  parameter int Nbits    = DEF_NBITS,
  parameter int NBUNDLES = DEF_NBUNDLES
) (
  input  logic                              clk,
  input  logic                              syn_rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [Nbits-1:0]                  in_bundle,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [Nbits-1:0]                  out_bundle,
  output logic                              busy,
  output logic                              layer_done,
  output logic [1:0]                        dbg_state,
  output logic [clog2_min1(NBUNDLES)-1:0]   dbg_bund_cnt
);

  localparam int NSLICE = 1 << PDLBOX;
  localparam int SW     = Nbits / NSLICE;
  localparam int SCW    = clog2_min1(NSLICE);
  localparam int BW     = clog2_min1(NBUNDLES);
  localparam logic [SCW-1:0] LAST_SLICE = SCW'(NSLICE - 1);
  localparam logic [BW-1:0]  LAST_BUND  = BW'(NBUNDLES - 1);

  seq_state_t       r_state;
  logic [SCW-1:0]   r_slice_cnt;
  logic [BW-1:0]    r_bund_cnt;
  logic [Nbits-1:0] r_data;
  logic [Nbits-1:0] r_result;
  logic             r_out_valid;
  logic             r_layer_done;
  logic             r_busy;
  logic             r_in_ready;

  logic [SW-1:0]    w_slice;
  logic [SW-1:0]    w_lbox;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;

`ifdef LBOX_LAYER_SEQ_OVERLAP_EN
  // r_out_valid is high exactly in OUT, where ready mirrors the consumer.
  assign w_in_ready = r_in_ready | (r_out_valid & out_ready);
`else
  assign w_in_ready = r_in_ready;
`endif

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Slice mux feeding the shared Lbox datapath.
  assign w_slice = r_data[int'(r_slice_cnt)*SW +: SW];

  lbox_unit #(
    .PDLBOX (PDLBOX),
    .Nbits  (Nbits)
  ) u_lbox (
    .i_slice (w_slice),
    .o_slice (w_lbox)
  );

  // Sequencer FSM, counters and result assembly; all outputs registered.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      r_state      <= ST_IDLE;
      r_slice_cnt  <= '0;
      r_bund_cnt   <= '0;
      r_data       <= '0;
      r_result     <= '0;
      r_out_valid  <= 1'b0;
      r_layer_done <= 1'b0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_layer_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_data      <= in_bundle;
            r_slice_cnt <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result[int'(r_slice_cnt)*SW +: SW] <= w_lbox;
          if (r_slice_cnt == LAST_SLICE) begin
            r_slice_cnt <= '0;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_slice_cnt <= r_slice_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (r_bund_cnt == LAST_BUND) begin
              r_bund_cnt   <= '0;
              r_layer_done <= 1'b1;
            end else begin
              r_bund_cnt <= r_bund_cnt + 1'b1;
            end
            // w_in_fire can only be set here when overlap is built in.
            if (w_in_fire) begin
              r_data      <= in_bundle;
              r_slice_cnt <= '0;
              r_state     <= ST_RUN;
            end else begin
              r_busy     <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = r_out_valid;
  assign out_bundle   = r_result;
  assign busy         = r_busy;
  assign layer_done   = r_layer_done;
  assign dbg_state    = r_state;
  assign dbg_bund_cnt = r_bund_cnt;

endmodule

// File: tb/tb_lbox_layer_seq.sv
// Bench for lbox_layer_seq: one instance with PDLBOX=0 and one with
// PDLBOX=1 share the same input stimulus and are checked side by side.
module tb_lbox_layer_seq;
  import shadow_pkg::*;

  localparam int NB = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          syn_rst;
  logic          in_valid;
  logic          out_ready;
  logic [NB-1:0] in_bundle;

  wire  [1:0]    in_ready;
  wire  [1:0]    out_valid;
  wire  [1:0]    busy;
  wire  [1:0]    layer_done;
  wire  [NB-1:0] out_bundle [2];
  wire  [1:0]    dbg_state  [2];
  wire  [1:0]    dbg_bund   [2];

  lbox_layer_seq #(.PDLBOX(0), .Nbits(NB), .NBUNDLES(4)) u_dut0 (
    .clk(clk), .syn_rst(syn_rst),
    .in_valid(in_valid), .in_ready(in_ready[0]), .in_bundle(in_bundle),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_bundle(out_bundle[0]),
    .busy(busy[0]), .layer_done(layer_done[0]),
    .dbg_state(dbg_state[0]), .dbg_bund_cnt(dbg_bund[0])
  );

  lbox_layer_seq #(.PDLBOX(1), .Nbits(NB), .NBUNDLES(4)) u_dut1 (
    .clk(clk), .syn_rst(syn_rst),
    .in_valid(in_valid), .in_ready(in_ready[1]), .in_bundle(in_bundle),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_bundle(out_bundle[1]),
    .busy(busy[1]), .layer_done(layer_done[1]),
    .dbg_state(dbg_state[1]), .dbg_bund_cnt(dbg_bund[1])
  );

  // ---------------- scoreboard ----------------
  int            n_cmp;
  int            n_err;
  int            exp_bund;
  int            done_seen;
  logic [NB-1:0] exp_q [$];

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Golden Lbox on one 64-bit lane (x low word, y high word).
  function automatic logic [31:0] ror(input logic [31:0] v, input int n);
    logic [63:0] t;
    t = {v, v} >> n;
    return t[31:0];
  endfunction

  function automatic logic [63:0] gold64(input logic [63:0] s);
    logic [31:0] x, y, a, b, c, d;
    x = s[31:0];
    y = s[63:32];
    a = x ^ ror(x, 12) ^ ror(x ^ ror(x, 12), 3) ^ ror(x, 17);
    b = y ^ ror(y, 12) ^ ror(y ^ ror(y, 12), 3) ^ ror(y, 17);
    c = a ^ ror(a, 31);
    d = b ^ ror(b, 31);
    return {b ^ ror(c, 25) ^ ror(d, 15), a ^ ror(d, 26) ^ ror(c, 15)};
  endfunction

  function automatic logic [NB-1:0] gold128(input logic [NB-1:0] s);
    return {gold64(s[127:64]), gold64(s[63:0])};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    syn_rst = 1'b1;
    tick();
    syn_rst = 1'b0;
    exp_bund = 0;
  endtask

  // One bundle through both DUTs: latency, data, optional backpressure,
  // handshake and layer bookkeeping.
  task automatic xfer(input string tag, input logic [NB-1:0] b, input int hold);
    logic [NB-1:0] exp;
    logic [NB-1:0] snap0;
    logic [NB-1:0] snap1;
    logic          stable;
    logic          exp_done;
    int            waited;
    int            lat0;
    int            lat1;
    exp = exp_q.pop_front();
    waited = 0;
    while (in_ready !== 2'b11 && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "/in_ready"}, NB'(in_ready), NB'(2'b11));
    in_bundle = b;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_bundle = ~b;
    check({tag, "/run"}, NB'({busy, in_ready, out_valid}), NB'(6'b11_00_00));
    lat0 = 0;
    lat1 = 0;
    for (int c = 1; c <= 8 && (lat0 == 0 || lat1 == 0); c++) begin
      tick();
      if (lat0 == 0 && out_valid[0]) lat0 = c;
      if (lat1 == 0 && out_valid[1]) lat1 = c;
    end
    check({tag, "/lat0"}, NB'(lat0), NB'(1));
    check({tag, "/lat1"}, NB'(lat1), NB'(2));
    check({tag, "/data0"}, out_bundle[0], exp);
    check({tag, "/data1"}, out_bundle[1], exp);
    snap0  = out_bundle[0];
    snap1  = out_bundle[1];
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      in_bundle = {4{$urandom}};
      tick();
      if (out_bundle[0] !== snap0 || out_bundle[1] !== snap1 || out_valid !== 2'b11 ||
          in_ready !== 2'b00 || dbg_bund[0] !== 2'(exp_bund) || dbg_bund[1] !== 2'(exp_bund))
        stable = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "/hold_stable"}, NB'(stable), NB'(1'b1));
    exp_done = (exp_bund == 3);
    exp_bund = (exp_bund + 1) % 4;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/done"}, NB'(layer_done), NB'({exp_done, exp_done}));
    check({tag, "/after_hs"}, NB'({out_valid, busy, in_ready}), NB'(6'b00_00_11));
    check({tag, "/bund0"}, NB'(dbg_bund[0]), NB'(exp_bund));
    check({tag, "/bund1"}, NB'(dbg_bund[1]), NB'(exp_bund));
    if (layer_done == 2'b11) done_seen++;
    tick();
    check({tag, "/single"}, NB'({out_valid, layer_done}), NB'(4'b0000));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [NB-1:0] v;
    int            first_acc [2];
    int            fourth    [2];
    int            outs      [2];
    int            span_exp  [2];
    logic          data_ok;
    n_cmp     = 0;
    n_err     = 0;
    exp_bund  = 0;
    done_seen = 0;
    syn_rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_bundle = '0;
    tick();
    tick();

    // State held in reset.
    check("rst/state0", NB'(dbg_state[0]), NB'(ST_IDLE));
    check("rst/state1", NB'(dbg_state[1]), NB'(ST_IDLE));
    check("rst/flags", NB'({in_ready, out_valid, busy, layer_done}), NB'(8'b11_00_00_00));
    check("rst/bund", NB'({dbg_bund[0], dbg_bund[1]}), NB'(4'b0000));
    check("rst/out", out_bundle[0] | out_bundle[1], '0);
    syn_rst = 1'b0;

    // Directed vectors; Lbox(0)=0 and Lbox(all ones)=all ones by hand.
    exp_q.push_back('0);
    xfer("zero", '0, 0);
    exp_q.push_back({NB{1'b1}});
    xfer("ones", {NB{1'b1}}, 0);
    v = 128'h0123456789ABCDEF_FEDCBA9876543210;
    exp_q.push_back(gold128(v));
    xfer("mix_bp", v, 10);
    v = 128'h80000000_00000000_00000000_00000001;
    exp_q.push_back(gold128(v));
    xfer("bits", v, 0);

    // Reset while a bundle is in flight.
    exp_q.push_back(gold128(128'h5));
    xfer("pre_rst", 128'h5, 0);
    in_bundle = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mid/state1", NB'(dbg_state[1]), NB'(ST_RUN));
    syn_rst = 1'b1;
    tick();
    syn_rst  = 1'b0;
    exp_bund = 0;
    check("mid/state0", NB'(dbg_state[0]), NB'(ST_IDLE));
    check("mid/state1_idle", NB'(dbg_state[1]), NB'(ST_IDLE));
    check("mid/flags", NB'({in_ready, out_valid, busy, layer_done}), NB'(8'b11_00_00_00));
    check("mid/bund", NB'({dbg_bund[0], dbg_bund[1]}), NB'(4'b0000));
    tick();
    check("mid/no_out", NB'({out_valid, layer_done}), NB'(4'b0000));

    // Two full layers of random bundles.
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(gold128(v));
      xfer($sformatf("layer%0d", i), v, 0);
    end
    check("layer/done_count", NB'(done_seen), NB'(2));

    // Streaming with in_valid and out_ready held high.
    do_reset();
    v = 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    in_bundle = v;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    data_ok   = 1'b1;
    for (int d = 0; d < 2; d++) begin
      first_acc[d] = -1;
      fourth[d]    = -1;
      outs[d]      = 0;
    end
    for (int e = 0; e < 40; e++) begin
      for (int d = 0; d < 2; d++) begin
        if (in_ready[d] && first_acc[d] < 0) first_acc[d] = e;
        if (out_valid[d]) begin
          outs[d]++;
          if (out_bundle[d] !== gold128(v)) data_ok = 1'b0;
          if (outs[d] == 4) fourth[d] = e;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
`ifdef LBOX_LAYER_SEQ_OVERLAP_EN
    span_exp[0] = 4 * 2;
    span_exp[1] = 4 * 3;
`else
    span_exp[0] = 3 * 3 + 2;
    span_exp[1] = 3 * 4 + 3;
`endif
    check("stream/span0", NB'(fourth[0] - first_acc[0]), NB'(span_exp[0]));
    check("stream/span1", NB'(fourth[1] - first_acc[1]), NB'(span_exp[1]));
    check("stream/data", NB'(data_ok), NB'(1'b1));
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
